// File: rtl/spmv_mem_pkg.sv
// Shared widths and the response-entry layout for the spmv_pe memory responder.
// Constants: tag width, data width, byte-address width, byte-to-word shift.
// Types: spmv_rsp_t is one response FIFO entry, {tag, data}.
package spmv_mem_pkg;

    localparam int unsigned SPMV_TAG_W      = 3;
    localparam int unsigned SPMV_DATA_W     = 64;
    localparam int unsigned SPMV_ADDR_W     = 48;
    localparam int unsigned SPMV_WORD_SHIFT = 3;
    localparam int unsigned SPMV_RSP_W      = SPMV_TAG_W + SPMV_DATA_W;

    typedef struct packed {
        logic [SPMV_TAG_W-1:0]  tag;
        logic [SPMV_DATA_W-1:0] data;
    } spmv_rsp_t;

endpackage

// File: rtl/spmv_rsp_fifo.sv
// Response FIFO for the memory responder.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset (empties the FIFO)
//   wr_en/wdata  enqueue one entry (ignored when full)
//   rd_en        dequeue the head (ignored when empty)
//   rdata        current head entry, combinational from storage
//   count        number of stored entries, 0..DEPTH
//   empty        no entries stored
module spmv_rsp_fifo #(
    parameter int unsigned WIDTH = 67,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [PW:0]      cnt_q, cnt_d;
    logic             full;
    logic             do_wr, do_rd;

    assign full  = (cnt_q == (PW+1)'(DEPTH));
    assign empty = (cnt_q == '0);
    assign do_wr = wr_en & ~full;
    assign do_rd = rd_en & ~empty;
    assign rdata = mem[rd_ptr_q];
    assign count = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        case ({do_wr, do_rd})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    // Storage carries no reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr_q] <= wdata;
        end
    end

    // DEPTH is a power of two, so pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/spmv_mem_responder.sv
// Memory responder for the spmv_pe req_mem_*/rsp_mem_* interface.
// Executes 8-byte loads/stores against a single-port backing memory, returns load data with
// its tag after LATENCY cycles, buffers responses while the PE stalls, and throttles the PE
// with a credit counter so the response FIFO can never overflow.
// Ports:
//   clk, rst_n                        clock, asynchronous active-low reset
//   req_mem_ld/st/addr/d_or_tag       PE request (one-cycle valid)
//   req_mem_stall                     credits exhausted
//   rsp_mem_push/tag/q                registered load response
//   rsp_mem_stall                     PE cannot take responses
//   mem_rd_en/wr_en/addr/wdata/rdata  backing memory (rdata one cycle after rd_en)
//   proto_err                         sticky protocol-violation flag
// Optional: define SPMV_MEM_RSP_STATS_EN to add stat_ld_cnt, stat_st_cnt, stat_stall_cyc.
module spmv_mem_responder
    import spmv_mem_pkg::*;
#(
    parameter int unsigned LATENCY    = 10,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned MEM_AW     = 20
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req_mem_ld,
    input  logic                   req_mem_st,
    input  logic [SPMV_ADDR_W-1:0] req_mem_addr,
    input  logic [SPMV_DATA_W-1:0] req_mem_d_or_tag,
    output logic                   req_mem_stall,
    output logic                   rsp_mem_push,
    output logic [SPMV_TAG_W-1:0]  rsp_mem_tag,
    output logic [SPMV_DATA_W-1:0] rsp_mem_q,
    input  logic                   rsp_mem_stall,
    output logic                   mem_rd_en,
    output logic                   mem_wr_en,
    output logic [MEM_AW-1:0]      mem_addr,
    output logic [SPMV_DATA_W-1:0] mem_wdata,
    input  logic [SPMV_DATA_W-1:0] mem_rdata,
`ifdef SPMV_MEM_RSP_STATS_EN
    output logic [31:0]            stat_ld_cnt,
    output logic [31:0]            stat_st_cnt,
    output logic [31:0]            stat_stall_cyc,
`endif
    output logic                   proto_err
);

    localparam int unsigned STAGES = LATENCY - 2;
    localparam int unsigned CW     = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned WLO    = SPMV_WORD_SHIFT;
    localparam int unsigned WHI    = MEM_AW + SPMV_WORD_SHIFT;

    // ---------------------------------------------------------------- accept / memory
    logic ld_acc, st_acc, acc_ok, req_any, addr_oob, viol;

    // Nothing reaches memory while reset is asserted.
    assign acc_ok  = rst_n & ~req_mem_stall;
    assign st_acc  = req_mem_st & acc_ok;
    assign ld_acc  = req_mem_ld & ~req_mem_st & acc_ok;
    assign req_any = req_mem_ld | req_mem_st;

    assign mem_rd_en = ld_acc;
    assign mem_wr_en = st_acc;
    assign mem_addr  = (ld_acc | st_acc) ? req_mem_addr[WHI-1:WLO] : '0;
    assign mem_wdata = st_acc ? req_mem_d_or_tag : '0;

    assign addr_oob = |req_mem_addr[SPMV_ADDR_W-1:WHI];
    assign viol     = (req_mem_ld & req_mem_st)
                    | (req_any & req_mem_stall)
                    | ((ld_acc | st_acc) & addr_oob);

    logic proto_err_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) proto_err_q <= 1'b0;
        else        proto_err_q <= proto_err_q | viol;
    end
    assign proto_err = proto_err_q;

    // ---------------------------------------------------------------- load delay line
    logic [STAGES-1:0]     dl_vld_q;
    logic [SPMV_TAG_W-1:0] dl_tag_q [STAGES];
    logic [SPMV_DATA_W-1:0] tail_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dl_vld_q <= '0;
        end else begin
            for (int i = int'(STAGES) - 1; i > 0; i--) dl_vld_q[i] <= dl_vld_q[i-1];
            dl_vld_q[0] <= ld_acc;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = int'(STAGES) - 1; i > 0; i--) dl_tag_q[i] <= dl_tag_q[i-1];
        dl_tag_q[0] <= req_mem_d_or_tag[SPMV_TAG_W-1:0];
    end

    // mem_rdata arrives while the tag sits in stage 0, so data joins at stage 1.
    // dl_data_q[k] is aligned with dl_vld_q[k+1].
    if (LATENCY == 3) begin : g_data_direct
        assign tail_data = mem_rdata;
    end else begin : g_data_pipe
        logic [SPMV_DATA_W-1:0] dl_data_q [LATENCY-3];
        always_ff @(posedge clk) begin
            for (int i = int'(LATENCY) - 4; i > 0; i--) dl_data_q[i] <= dl_data_q[i-1];
            dl_data_q[0] <= mem_rdata;
        end
        assign tail_data = dl_data_q[LATENCY-4];
    end

    // ---------------------------------------------------------------- response FIFO
    spmv_rsp_t       fifo_wdata, fifo_rdata;
    logic [CW-1:0]   fifo_count;
    logic            fifo_empty;
    logic            pop;

    assign fifo_wdata = '{tag: dl_tag_q[STAGES-1], data: tail_data};
    assign pop        = ~rsp_mem_stall & ~fifo_empty;

    spmv_rsp_fifo #(
        .WIDTH (SPMV_RSP_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .wr_en (dl_vld_q[STAGES-1]),
        .wdata (fifo_wdata),
        .rd_en (pop),
        .rdata (fifo_rdata),
        .count (fifo_count),
        .empty (fifo_empty)
    );

    // ---------------------------------------------------------------- output register
    logic                   push_q;
    logic [SPMV_TAG_W-1:0]  tag_q;
    logic [SPMV_DATA_W-1:0] data_q;

    // Tag/data hold their last value while no head is popped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            push_q <= 1'b0;
            tag_q  <= '0;
            data_q <= '0;
        end else begin
            push_q <= pop;
            if (pop) begin
                tag_q  <= fifo_rdata.tag;
                data_q <= fifo_rdata.data;
            end
        end
    end

    assign rsp_mem_push = push_q;
    assign rsp_mem_tag  = tag_q;
    assign rsp_mem_q    = data_q;

    // ---------------------------------------------------------------- credits
    // Outstanding = loads in the delay line + FIFO entries. The output register is not
    // counted: a popped response is already handed to the PE.
    logic [CW-1:0] out_q, out_d;

    always_comb begin
        out_d = out_q;
        case ({ld_acc, pop})
            2'b10:   out_d = out_q + 1'b1;
            2'b01:   out_d = out_q - 1'b1;
            default: out_d = out_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) out_q <= '0;
        else        out_q <= out_d;
    end

    assign req_mem_stall = (out_q >= CW'(FIFO_DEPTH));

    logic unused_sink;
    assign unused_sink = ^{req_mem_addr[WLO-1:0], fifo_count};

    // ---------------------------------------------------------------- statistics
`ifdef SPMV_MEM_RSP_STATS_EN
    logic [31:0] ld_cnt_q, st_cnt_q, stall_cyc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ld_cnt_q    <= '0;
            st_cnt_q    <= '0;
            stall_cyc_q <= '0;
        end else begin
            if (ld_acc && ld_cnt_q != '1) ld_cnt_q <= ld_cnt_q + 1'b1;
            if (st_acc && st_cnt_q != '1) st_cnt_q <= st_cnt_q + 1'b1;
            if (rsp_mem_stall && !fifo_empty && stall_cyc_q != '1) begin
                stall_cyc_q <= stall_cyc_q + 1'b1;
            end
        end
    end

    assign stat_ld_cnt    = ld_cnt_q;
    assign stat_st_cnt    = st_cnt_q;
    assign stat_stall_cyc = stall_cyc_q;
`endif

endmodule

// File: tb/tb_spmv_mem_responder.sv
// Directed self-checking bench for spmv_mem_responder (default parameters).
module tb_spmv_mem_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_mem_ld, req_mem_st;
    logic [47:0] req_mem_addr;
    logic [63:0] req_mem_d_or_tag;
    logic        req_mem_stall;
    logic        rsp_mem_push;
    logic [2:0]  rsp_mem_tag;
    logic [63:0] rsp_mem_q;
    logic        rsp_mem_stall;
    logic        mem_rd_en, mem_wr_en;
    logic [19:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata = '0;
    logic        proto_err;
`ifdef SPMV_MEM_RSP_STATS_EN
    logic [31:0] stat_ld_cnt, stat_st_cnt, stat_stall_cyc;
`endif

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    spmv_mem_responder dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .req_mem_ld       (req_mem_ld),
        .req_mem_st       (req_mem_st),
        .req_mem_addr     (req_mem_addr),
        .req_mem_d_or_tag (req_mem_d_or_tag),
        .req_mem_stall    (req_mem_stall),
        .rsp_mem_push     (rsp_mem_push),
        .rsp_mem_tag      (rsp_mem_tag),
        .rsp_mem_q        (rsp_mem_q),
        .rsp_mem_stall    (rsp_mem_stall),
        .mem_rd_en        (mem_rd_en),
        .mem_wr_en        (mem_wr_en),
        .mem_addr         (mem_addr),
        .mem_wdata        (mem_wdata),
        .mem_rdata        (mem_rdata),
`ifdef SPMV_MEM_RSP_STATS_EN
        .stat_ld_cnt      (stat_ld_cnt),
        .stat_st_cnt      (stat_st_cnt),
        .stat_stall_cyc   (stat_stall_cyc),
`endif
        .proto_err        (proto_err)
    );

    // Backing memory: unwritten words read as a fixed pattern of their index.
    logic [63:0] wmem [256];
    bit          wvld [256];

    function automatic logic [63:0] dflt(int idx);
        if (idx == 8) return 64'hDEAD;
        return 64'h1000 + 64'(idx);
    endfunction

    always @(posedge clk) begin
        if (mem_wr_en) begin
            wmem[mem_addr[7:0]] <= mem_wdata;
            wvld[mem_addr[7:0]] <= 1'b1;
        end
        if (mem_rd_en) begin
            mem_rdata <= wvld[mem_addr[7:0]] ? wmem[mem_addr[7:0]] : dflt(int'(mem_addr[7:0]));
        end
    end

    // Response monitor: sampled mid-cycle.
    logic [2:0]  rq_tag [$];
    logic [63:0] rq_data [$];
    int          rq_cyc [$];

    always @(negedge clk) begin
        if (rsp_mem_push) begin
            rq_tag.push_back(rsp_mem_tag);
            rq_data.push_back(rsp_mem_q);
            rq_cyc.push_back(cyc);
        end
    end

    function automatic logic [63:0] r_data(int i);
        if (i < rq_data.size()) return rq_data[i];
        return '1;
    endfunction
    function automatic logic [63:0] r_tag(int i);
        if (i < rq_tag.size()) return 64'(rq_tag[i]);
        return '1;
    endfunction
    function automatic logic [63:0] r_cyc(int i);
        if (i < rq_cyc.size()) return 64'(rq_cyc[i]);
        return '1;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req_mem_ld       = 1'b0;
        req_mem_st       = 1'b0;
        req_mem_addr     = '0;
        req_mem_d_or_tag = '0;
    endtask

    task automatic issue_ld(input logic [47:0] addr, input logic [2:0] tag);
        req_mem_ld       = 1'b1;
        req_mem_addr     = addr;
        req_mem_d_or_tag = 64'(tag);
        tick();
        idle_inputs();
    endtask

    task automatic issue_st(input logic [47:0] addr, input logic [63:0] d);
        req_mem_st       = 1'b1;
        req_mem_addr     = addr;
        req_mem_d_or_tag = d;
        tick();
        idle_inputs();
    endtask

    task automatic do_reset();
        idle_inputs();
        rsp_mem_stall = 1'b0;
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        int base, t0, acc;
        logic s15, s16;

        idle_inputs();
        rsp_mem_stall = 1'b0;
        rst_n = 1'b0;
        repeat (3) tick();

        // Reset state
        check("rst_push", 64'(rsp_mem_push), 64'd0);
        check("rst_req_stall", 64'(req_mem_stall), 64'd0);
        check("rst_proto", 64'(proto_err), 64'd0);
        check("rst_q", rsp_mem_q, 64'd0);
        check("rst_rd_en", 64'(mem_rd_en), 64'd0);
        rst_n = 1'b1;
        tick();

        // Single load: latency 10, tag and data
        base = rq_tag.size();
        t0   = cyc;
        issue_ld(48'h40, 3'd5);
        repeat (14) tick();
        check("t1_count", 64'(rq_tag.size() - base), 64'd1);
        check("t1_latency", r_cyc(base) - 64'(t0), 64'd10);
        check("t1_tag", r_tag(base), 64'd5);
        check("t1_q", r_data(base), 64'hDEAD);

        // Store then load same word
        base = rq_tag.size();
        issue_st(48'h80, 64'h1234);
        issue_ld(48'h80, 3'd2);
        repeat (14) tick();
        check("t2_count", 64'(rq_tag.size() - base), 64'd1);
        check("t2_tag", r_tag(base), 64'd2);
        check("t2_q", r_data(base), 64'h1234);
        check("t2_proto", 64'(proto_err), 64'd0);

        // Out-of-range word index: truncated access plus sticky error
        base = rq_tag.size();
        issue_ld(48'h80_0040, 3'd1);
        repeat (14) tick();
        check("oob_count", 64'(rq_tag.size() - base), 64'd1);
        check("oob_q", r_data(base), 64'hDEAD);
        check("oob_proto", 64'(proto_err), 64'd1);
        do_reset();
        check("oob_proto_cleared", 64'(proto_err), 64'd0);

        // Credit exhaustion under sustained response stall
        base = rq_tag.size();
        rsp_mem_stall = 1'b1;
        acc = 0;
        s15 = 1'b0;
        s16 = 1'b0;
        for (int i = 0; i < 20; i++) begin
            req_mem_ld       = 1'b1;
            req_mem_addr     = 48'h100 + 48'(8 * i);
            req_mem_d_or_tag = 64'(i % 8);
            if (i == 15) s15 = req_mem_stall;
            if (i == 16) s16 = req_mem_stall;
            if (!req_mem_stall) acc++;
            tick();
        end
        idle_inputs();
        repeat (15) tick();
        check("t3_accepted", 64'(acc), 64'd16);
        check("t3_stall_c15", 64'(s15), 64'd0);
        check("t3_stall_c16", 64'(s16), 64'd1);
        check("t3_no_push_stalled", 64'(rq_tag.size() - base), 64'd0);
        check("t3_stall_held", 64'(req_mem_stall), 64'd1);
        check("t3_proto", 64'(proto_err), 64'd1);
        rsp_mem_stall = 1'b0;
        repeat (25) tick();
        check("t3_count", 64'(rq_tag.size() - base), 64'd16);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("t3_tag%0d", i), r_tag(base + i), 64'(i % 8));
            check($sformatf("t3_q%0d", i), r_data(base + i), 64'h1000 + 64'(32 + i));
        end
        check("t3_stall_released", 64'(req_mem_stall), 64'd0);
        do_reset();

        // Toggling response stall
        base = rq_tag.size();
        for (int i = 0; i < 8; i++) begin
            rsp_mem_stall = i[0];
            issue_ld(48'h400 + 48'(8 * i), 3'((i + 3) % 8));
        end
        for (int j = 0; j < 30; j++) begin
            rsp_mem_stall = ~rsp_mem_stall;
            tick();
        end
        rsp_mem_stall = 1'b0;
        repeat (4) tick();
        check("t4_count", 64'(rq_tag.size() - base), 64'd8);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("t4_tag%0d", i), r_tag(base + i), 64'((i + 3) % 8));
            check($sformatf("t4_q%0d", i), r_data(base + i), 64'h1000 + 64'(128 + i));
        end
        check("t4_proto", 64'(proto_err), 64'd0);

        // ld+st in the same cycle
        base = rq_tag.size();
        req_mem_ld       = 1'b1;
        req_mem_st       = 1'b1;
        req_mem_addr     = 48'h200;
        req_mem_d_or_tag = 64'hABCD;
        tick();
        idle_inputs();
        check("t5_proto_set", 64'(proto_err), 64'd1);
        repeat (14) tick();
        check("t5_no_rsp", 64'(rq_tag.size() - base), 64'd0);
        issue_ld(48'h200, 3'd4);
        repeat (14) tick();
        check("t5_rd_count", 64'(rq_tag.size() - base), 64'd1);
        check("t5_rd_q", r_data(base), 64'hABCD);
        check("t5_rd_tag", r_tag(base), 64'd4);
        check("t5_proto_sticky", 64'(proto_err), 64'd1);
        do_reset();
        check("t5_proto_cleared", 64'(proto_err), 64'd0);

        // Reset with loads in flight
        issue_ld(48'h40, 3'd7);
        repeat (11) tick();
        check("t6_pre_q", rsp_mem_q, 64'hDEAD);
        check("t6_pre_tag", 64'(rsp_mem_tag), 64'd7);
        for (int i = 0; i < 5; i++) issue_ld(48'h300 + 48'(8 * i), 3'(i));
        repeat (2) tick();
        base = rq_tag.size();
        rst_n = 1'b0;
        #1;
        check("t6_rst_q", rsp_mem_q, 64'd0);
        check("t6_rst_tag", 64'(rsp_mem_tag), 64'd0);
        check("t6_rst_push", 64'(rsp_mem_push), 64'd0);
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (20) tick();
        check("t6_no_rsp", 64'(rq_tag.size() - base), 64'd0);
        check("t6_stall", 64'(req_mem_stall), 64'd0);
        rsp_mem_stall = 1'b1;
        acc = 0;
        for (int i = 0; i < 17; i++) begin
            req_mem_ld       = 1'b1;
            req_mem_addr     = 48'h100 + 48'(8 * i);
            req_mem_d_or_tag = 64'(i % 8);
            if (!req_mem_stall) acc++;
            tick();
        end
        idle_inputs();
        check("t6_credits", 64'(acc), 64'd16);
        check("t6_stall_full", 64'(req_mem_stall), 64'd1);
        rsp_mem_stall = 1'b0;
        repeat (30) tick();
        check("t6_stall_drained", 64'(req_mem_stall), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
